// File: rtl/full_subtractor.sv
// ============================================================================
// Module   : full_subtractor
// Brief    : 1-bit full-subtractor cell (difference and borrow-out).
// Revision : 1.0
// ============================================================================
`default_nettype none

module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

`default_nettype wire

// File: rtl/param_subtractor.sv
// ============================================================================
// Module   : param_subtractor
// Brief    : SIZE-bit unsigned ripple-borrow subtractor with registered,
//            valid-qualified result and borrow flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module param_subtractor #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] diff,
  output logic            borrow,
  output logic            out_valid
);

  logic [SIZE:0]   borrow_chain;
  logic [SIZE-1:0] core_diff;

  logic [SIZE-1:0] diff_d, diff_q;
  logic            borrow_d, borrow_q;
  logic            out_valid_d, out_valid_q;

  assign borrow_chain[0] = 1'b0;

  generate
    for (genvar i = 0; i < SIZE; i++) begin : g_cell
      full_subtractor u_fs (
        .x    (a[i]),
        .y    (b[i]),
        .bin  (borrow_chain[i]),
        .d    (core_diff[i]),
        .bout (borrow_chain[i+1])
      );
    end
  endgenerate

  // Result registers hold their value when no new operands are presented.
  always_comb begin
    diff_d      = diff_q;
    borrow_d    = borrow_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      diff_d   = core_diff;
      borrow_d = borrow_chain[SIZE];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_param_subtractor.sv
// ============================================================================
// Module   : tb_param_subtractor
// Brief    : Scoreboard bench for param_subtractor at SIZE=2 and SIZE=8.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_param_subtractor;

  logic       clk;
  logic       rst_n;

  logic       in_valid2;
  logic [1:0] a2, b2, diff2;
  logic       borrow2, out_valid2;

  logic       in_valid8;
  logic [7:0] a8, b8, diff8;
  logic       borrow8, out_valid8;

  int passed;
  int total;

  logic [2:0] q2[$];
  logic [8:0] q8[$];
  logic [2:0] last2;
  logic [8:0] last8;

  param_subtractor #(.SIZE(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .a         (a2),
    .b         (b2),
    .diff      (diff2),
    .borrow    (borrow2),
    .out_valid (out_valid2)
  );

  param_subtractor #(.SIZE(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .a         (a8),
    .b         (b8),
    .diff      (diff8),
    .borrow    (borrow8),
    .out_valid (out_valid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step2(input logic v, input logic [1:0] av, input logic [1:0] bv);
    @(negedge clk);
    in_valid2 = v;
    a2        = av;
    b2        = bv;
    if (v) q2.push_back({1'b0, av} - {1'b0, bv});
    @(posedge clk);
    #1;
    chk("out_valid2", {31'd0, out_valid2}, {31'd0, v});
    if (v) begin
      if (q2.size() == 0) begin
        total++;
        $error("FAIL scoreboard2_empty observed=0 expected=1");
      end else begin
        last2 = q2.pop_front();
      end
    end
    chk("diff2", {30'd0, diff2}, {30'd0, last2[1:0]});
    chk("borrow2", {31'd0, borrow2}, {31'd0, last2[2]});
  endtask

  task automatic step8(input logic v, input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    in_valid8 = v;
    a8        = av;
    b8        = bv;
    if (v) q8.push_back({1'b0, av} - {1'b0, bv});
    @(posedge clk);
    #1;
    chk("out_valid8", {31'd0, out_valid8}, {31'd0, v});
    if (v) begin
      if (q8.size() == 0) begin
        total++;
        $error("FAIL scoreboard8_empty observed=0 expected=1");
      end else begin
        last8 = q8.pop_front();
      end
    end
    chk("diff8", {24'd0, diff8}, {24'd0, last8[7:0]});
    chk("borrow8", {31'd0, borrow8}, {31'd0, last8[8]});
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    last2     = '0;
    last8     = '0;
    rst_n     = 1'b0;
    in_valid2 = 1'b0;
    a2        = '0;
    b2        = '0;
    in_valid8 = 1'b0;
    a8        = '0;
    b8        = '0;

    // Reset state while rst_n is low
    #3;
    chk("rst_diff2", {30'd0, diff2}, 32'd0);
    chk("rst_borrow2", {31'd0, borrow2}, 32'd0);
    chk("rst_valid2", {31'd0, out_valid2}, 32'd0);
    chk("rst_diff8", {24'd0, diff8}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // No-borrow cases
    step2(1'b1, 2'b01, 2'b00);
    step2(1'b1, 2'b10, 2'b01);
    step2(1'b1, 2'b11, 2'b01);
    step2(1'b1, 2'b11, 2'b11);
    // Borrow / wrap cases
    step2(1'b1, 2'b00, 2'b01);
    step2(1'b1, 2'b01, 2'b10);
    step2(1'b1, 2'b01, 2'b11);

    // Hold: result stays, valid drops
    step2(1'b1, 2'b10, 2'b01);
    step2(1'b0, 2'b00, 2'b11);
    step2(1'b0, 2'b11, 2'b00);

    // Throughput: four back-to-back captures
    step2(1'b1, 2'b11, 2'b10);
    step2(1'b1, 2'b00, 2'b11);
    step2(1'b1, 2'b10, 2'b10);
    step2(1'b1, 2'b10, 2'b11);
    step2(1'b0, 2'b00, 2'b00);

    // Exhaustive sweep at SIZE=2
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        step2(1'b1, i[1:0], j[1:0]);
      end
    end

    // Mid-stream asynchronous reset discards the pending capture
    step2(1'b1, 2'b01, 2'b11);
    @(negedge clk);
    in_valid2 = 1'b1;
    a2        = 2'b11;
    b2        = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_diff2", {30'd0, diff2}, 32'd0);
    chk("midrst_borrow2", {31'd0, borrow2}, 32'd0);
    chk("midrst_valid2", {31'd0, out_valid2}, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_hold_diff2", {30'd0, diff2}, 32'd0);
    chk("midrst_hold_valid2", {31'd0, out_valid2}, 32'd0);
    q2.delete();
    last2 = '0;
    @(negedge clk);
    in_valid2 = 1'b0;
    rst_n     = 1'b1;
    step2(1'b1, 2'b10, 2'b00);

    // Width scaling at SIZE=8
    step8(1'b1, 8'h00, 8'h01);
    step8(1'b1, 8'hC8, 8'h64);
    step8(1'b1, 8'hFF, 8'hFF);
    step8(1'b1, 8'h64, 8'hC8);
    step8(1'b0, 8'h12, 8'h34);
    for (int k = 0; k < 8; k++) begin
      step8(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
